// File: rtl/riscv_pkg.sv
// Shared fetch-stage types and constants.
package riscv_pkg;

  localparam int unsigned WORD_SIZE   = 32;
  localparam int unsigned INSTR_BYTES = 4;

  typedef logic [WORD_SIZE-1:0] word_t;

  typedef struct packed {
    word_t pc;
    word_t instr;
  } fetch_entry_t;

endpackage

// File: rtl/riscv_fetch_if.sv
// Fetch-stage bus: instruction-memory read port plus the core-side handshake and redirect.
interface riscv_fetch_if #(
  parameter int unsigned WORD_SIZE = 32
);

  logic [WORD_SIZE-1:0] read_addr_o;
  logic [WORD_SIZE-1:0] read_data_i;
  logic                 redirect_i;
  logic [WORD_SIZE-1:0] redirect_pc_i;
  logic                 instr_valid_o;
  logic                 instr_ready_i;
  logic [WORD_SIZE-1:0] instr_o;
  logic [WORD_SIZE-1:0] instr_pc_o;
  logic                 misalign_o;

  modport master (
    output read_addr_o, instr_valid_o, instr_o, instr_pc_o, misalign_o,
    input  read_data_i, redirect_i, redirect_pc_i, instr_ready_i
  );

  modport slave (
    input  read_addr_o, instr_valid_o, instr_o, instr_pc_o, misalign_o,
    output read_data_i, redirect_i, redirect_pc_i, instr_ready_i
  );

endinterface

// File: rtl/riscv_fetch_sync_fifo.sv
// Synchronous FIFO parameterised on entry type; flush outranks push/pop, head reads 0 when empty.
module sync_fifo #(
  parameter type         T     = logic [63:0],
  parameter int unsigned DEPTH = 4,
  localparam int unsigned AW   = $clog2(DEPTH),
  localparam int unsigned CW   = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  T              wdata,
  output T              rdata,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  T           mem [DEPTH];
  logic [AW:0] wptr;
  logic [AW:0] rptr;

  logic do_push;
  logic do_pop;

  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !rst) mem[wptr[AW-1:0]] <= wdata;
  end

  // Extra pointer bit distinguishes full from empty.
  assign count = wptr - rptr;
  assign empty = (count == '0);
  assign full  = (count == CW'(DEPTH));
  assign rdata = empty ? '0 : mem[rptr[AW-1:0]];

endmodule

// File: rtl/riscv_fetch.sv
// Instruction fetch: PC, one-deep inflight tracking, issue throttling and redirect flush.
// Optional redirect-misalignment pulse enabled by `define FETCH_MISALIGN_CHK_EN.
module riscv_fetch #(
  parameter int unsigned          WORD_SIZE  = 32,
  parameter logic [WORD_SIZE-1:0] RESET_PC   = '0,
  parameter int unsigned          FIFO_DEPTH = 4
) (
  input logic           clk_i,
  input logic           rst_i,
  riscv_fetch_if.master bus
);

  import riscv_pkg::*;

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

  typedef struct packed {
    logic [WORD_SIZE-1:0] pc;
    logic [WORD_SIZE-1:0] instr;
  } entry_t;

  logic [WORD_SIZE-1:0] fpc;
  logic [WORD_SIZE-1:0] inflight_pc;
  logic                 inflight;
  logic                 issue;
  logic                 push;
  logic                 pop;
  logic                 full;
  logic                 empty;
  logic [CW-1:0]        count;
  logic [CW:0]          occupancy;
  entry_t               wentry;
  entry_t               rentry;

  // Outstanding request reserves a slot so a returning word always fits.
  always_comb occupancy = {1'b0, count} + {{CW{1'b0}}, inflight};
  assign issue = (occupancy < (CW+1)'(FIFO_DEPTH));

  assign push   = inflight && !full;
  assign pop    = bus.instr_valid_o && bus.instr_ready_i;
  assign wentry = '{pc: inflight_pc, instr: bus.read_data_i};

  sync_fifo #(
    .T     (entry_t),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk_i),
    .rst   (rst_i),
    .push  (push),
    .pop   (pop),
    .flush (bus.redirect_i),
    .wdata (wentry),
    .rdata (rentry),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      fpc         <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= '0;
    end else if (bus.redirect_i) begin
      fpc      <= {bus.redirect_pc_i[WORD_SIZE-1:2], 2'b00};
      inflight <= 1'b0;
    end else begin
      inflight <= issue;
      if (issue) begin
        inflight_pc <= fpc;
        fpc         <= fpc + WORD_SIZE'(INSTR_BYTES);
      end
    end
  end

  assign bus.read_addr_o   = fpc;
  assign bus.instr_valid_o = !empty && !bus.redirect_i;
  assign bus.instr_o       = rentry.instr;
  assign bus.instr_pc_o    = rentry.pc;

`ifdef FETCH_MISALIGN_CHK_EN
  logic misalign;

  always_ff @(posedge clk_i) begin
    if (rst_i) misalign <= 1'b0;
    else       misalign <= bus.redirect_i && (bus.redirect_pc_i[1:0] != 2'b00);
  end

  assign bus.misalign_o = misalign;
`else
  assign bus.misalign_o = 1'b0;
`endif

endmodule

// File: doc/riscv_fetch.md
# riscv_fetch

Instruction fetch stage between the instruction memory and `riscv_core`. It owns the program counter, issues one word-aligned read per cycle to the instruction memory, and buffers returned instructions with their PCs in a small FIFO. It presents them to the core over a valid/ready handshake. It also accepts branch/jump redirects from the core, flushing all stale fetches.

## Interface
Parameters:
- `WORD_SIZE`, 32: instruction, PC and address width.
- `RESET_PC`, 32'h0000_0000: first fetch address after reset.
- `FIFO_DEPTH`, 4: instruction buffer entries; power of two, ≥2.

Ports:
- `clk_i` in 1: clock, rising edge.
- `rst_i` in 1: reset, synchronous, active-high.
- `read_addr_o` out WORD_SIZE: byte address to instruction memory read port.
- `read_data_i` in WORD_SIZE: instruction memory data; valid exactly one cycle after the address.
- `redirect_i` in 1: core requests a PC change this cycle.
- `redirect_pc_i` in WORD_SIZE: redirect target.
- `instr_valid_o` out 1: `instr_o`/`instr_pc_o` hold a valid instruction.
- `instr_ready_i` in 1: core accepts the instruction; a transfer occurs when valid and ready are both high.
- `instr_o` out WORD_SIZE: instruction word.
- `instr_pc_o` out WORD_SIZE: PC of `instr_o`.
- `misalign_o` out 1: redirect target had nonzero `[1:0]`; pulses one cycle.

## Operation
- Fetch PC register `fpc`; `read_addr_o = fpc` (registered, no combinational path from inputs).
- Issue rule: a request issues in a cycle when `count + inflight < FIFO_DEPTH`, where `count` = FIFO occupancy and `inflight` = 1 if a request issued last cycle. On issue, `fpc <= fpc + 4`, modulo 2^WORD_SIZE; wrap from all-ones to 0 is legal.
- With no issue, `fpc` holds and `read_addr_o` is re-presented; memory data in cycles without an inflight request is ignored.
- Response: in the cycle after an issue, if not flushed, push `{pc, read_data_i}` into the FIFO. The pc is the issued address, tracked in a 1-deep inflight register.
- Output: `instr_valid_o = (count != 0) && !redirect_i`; the head entry drives `instr_o`/`instr_pc_o`. Pop occurs on `instr_valid_o && instr_ready_i`.
- Redirect:
  - Empty the FIFO.
  - Clear `inflight`, discarding the next cycle's `read_data_i`.
  - Set `fpc <= {redirect_pc_i[WORD_SIZE-1:2], 2'b00}`.
  - No pop is counted in a redirect cycle.
- Simultaneous redirect and issue: redirect wins; the issued request is dropped.
- Simultaneous push and pop: occupancy unchanged; a push into a full FIFO cannot occur, by construction of the issue rule.

## Timing
- Reset values:
  - `read_addr_o = RESET_PC`
  - `instr_valid_o = 0`, `misalign_o = 0`
  - FIFO empty, `inflight = 0`
  - `instr_o` and `instr_pc_o` are 0 while empty.
- Reset asserted mid-operation has the same effect as a redirect to `RESET_PC`, with no misalign pulse.
- First cycle after reset: address `RESET_PC` issued (C0), data returned (C1), `instr_valid_o` high (C2). The load-to-use fetch latency is 2 cycles.
- Redirect in cycle R: target address on `read_addr_o` in R+1, instruction valid in R+3.
- Throughput: 1 instruction/cycle sustained with `instr_ready_i` held high.
- Stall: `instr_ready_i` low fills the FIFO; issue stops at `FIFO_DEPTH` total entries and resumes the cycle after the first pop.

## Configuration
- `FETCH_MISALIGN_CHK_EN` defined:
  - `misalign_o` pulses high in R+1 when `redirect_pc_i[1:0] != 0` at redirect cycle R.
  - The aligned target is still fetched.
- Not defined: `misalign_o` is tied 0 and no check logic is generated; the port remains.

## Structure
- Shared package `riscv_pkg`:
  - `word_t` (`logic [WORD_SIZE-1:0]`)
  - `fetch_entry_t` struct `{word_t pc; word_t instr;}`
  - `INSTR_BYTES = 4`
- Sub-module `sync_fifo`, parameterised on entry type and depth.
  - Ports: push, pop, flush, full, empty, count.
  - Flush takes priority over push/pop.
- `riscv_fetch` holds the PC, inflight tracking, issue logic and redirect handling.

## Test plan
- Reset release, `instr_ready_i=1`, memory returns `addr^32'hA5A5_0000` → instructions for PCs 0x0, 0x4, 0x8 appear in cycles 2, 3, 4 with matching data.
- Ready held low 10 cycles → exactly 4 entries buffered, `read_addr_o` frozen at 0x10; ready high → PCs 0x0…0xC drain in order, fetch resumes at 0x10.
- Redirect to 0x100 at cycle 5 → no instruction with PC ≥ old stream is delivered after cycle 5; next valid is PC 0x100 at cycle 8.
- Redirect to 0x203 with macro defined → `misalign_o` pulses once, fetch starts at 0x200; with macro undefined → `misalign_o` stays 0.
- `RESET_PC=32'hFFFF_FFF8` → PCs FFFF_FFF8, FFFF_FFFC, 0x0 delivered consecutively.
- Reset asserted while FIFO is full and a request is inflight → next cycle `instr_valid_o=0`, `read_addr_o=RESET_PC`, no stale instruction ever delivered.
